// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Reset controller that gathers an asynchronous, possibly bouncing board reset
// request and a synchronous software reset pulse. It holds every reset domain
// asserted for a minimum time after the last request, then releases the domain
// resets one at a time (bit 0 first) with a fixed stagger. It also keeps a
// saturating count of accepted reset events.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset (deasserts synchronously)
//   hit_reset     in   asynchronous level reset request, active high, may bounce
//   sw_reset      in   synchronous single-cycle reset request, active high
//   reset_n_out   out  [NUM_OUT] sequenced active-low domain resets, thermometer
//   all_released  out  high when every reset_n_out bit is 1
//   busy          out  high whenever the sequencer is not in RUN
//   reset_count   out  [8] accepted reset events since reset_n, saturating
// -----------------------------------------------------------------------------
module reset_sequencer #(
   parameter int unsigned NUM_OUT         = 2,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES     = 8,
   parameter int unsigned STAGGER_CYCLES  = 4,
   parameter int unsigned CNT_W           = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               hit_reset,
   input  logic               sw_reset,
   output logic [NUM_OUT-1:0] reset_n_out,
   output logic               all_released,
   output logic               busy,
   output logic [7:0]         reset_count
);

   localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam int unsigned COUNT_W = 8;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DEB_W-1:0]       deb_q, deb_d;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       hold_q, hold_d;
   logic [CNT_W-1:0]       stag_q, stag_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_OUT-1:0]     out_q, out_d;
   logic                   all_rel_q, all_rel_d;
   logic                   busy_q, busy_d;
   logic [COUNT_W-1:0]     count_q, count_d;

   logic                   sync_s;
   logic                   req_lvl;
   logic                   req;
   logic [IDX_W-1:0]       next_idx;

   // ---------------------------------------------------------------------------
   // Synchroniser for the asynchronous hit_reset request
   // ---------------------------------------------------------------------------
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], hit_reset};
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Debounce: count consecutive synchronised-high cycles, saturating
   // ---------------------------------------------------------------------------
   always_comb begin
      deb_d = deb_q;
      if (!sync_s) begin
         deb_d = '0;
      end else if (deb_q != DEB_W'(DEBOUNCE_CYCLES)) begin
         deb_d = deb_q + DEB_W'(1);
      end
   end

   assign req_lvl = (deb_q == DEB_W'(DEBOUNCE_CYCLES));
   assign req     = req_lvl | sw_reset;

   // ---------------------------------------------------------------------------
   // Sequencer next-state and registered outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      stag_d    = stag_q;
      idx_d     = idx_q;
      out_d     = out_q;
      all_rel_d = all_rel_q;
      busy_d    = busy_q;
      count_d   = count_q;
      next_idx  = idx_q + IDX_W'(1);

      case (state_q)
         ST_HOLD: begin
            out_d     = '0;
            all_rel_d = 1'b0;
            busy_d    = 1'b1;
            // A request while already holding only restarts the hold window.
            if (req) begin
               hold_d = '0;
            end else if (hold_q == CNT_W'(HOLD_CYCLES - 1)) begin
               out_d  = NUM_OUT'(1);
               stag_d = '0;
               idx_d  = '0;
               if (NUM_OUT == 1) begin
                  state_d   = ST_RUN;
                  all_rel_d = 1'b1;
                  busy_d    = 1'b0;
               end else begin
                  state_d = ST_RELEASE;
               end
            end else begin
               hold_d = hold_q + CNT_W'(1);
            end
         end

         ST_RELEASE: begin
            if (req) begin
               // Abort drops every already-released domain together.
               state_d   = ST_HOLD;
               out_d     = '0;
               all_rel_d = 1'b0;
               busy_d    = 1'b1;
               hold_d    = '0;
               if (count_q != '1) count_d = count_q + COUNT_W'(1);
            end else if (stag_q == CNT_W'(STAGGER_CYCLES - 1)) begin
               stag_d = '0;
               idx_d  = next_idx;
               // Release exactly one more bit; keeps the thermometer shape.
               for (int unsigned i = 0; i < NUM_OUT; i++) begin
                  if (32'(next_idx) == i) out_d[i] = 1'b1;
               end
               if (32'(next_idx) == NUM_OUT - 1) begin
                  state_d   = ST_RUN;
                  all_rel_d = 1'b1;
                  busy_d    = 1'b0;
               end
            end else begin
               stag_d = stag_q + CNT_W'(1);
            end
         end

         ST_RUN: begin
            if (req) begin
               state_d   = ST_HOLD;
               out_d     = '0;
               all_rel_d = 1'b0;
               busy_d    = 1'b1;
               hold_d    = '0;
               if (count_q != '1) count_d = count_q + COUNT_W'(1);
            end else begin
               out_d     = '1;
               all_rel_d = 1'b1;
               busy_d    = 1'b0;
            end
         end

         default: begin
            state_d   = ST_HOLD;
            out_d     = '0;
            all_rel_d = 1'b0;
            busy_d    = 1'b1;
            hold_d    = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '0;
         deb_q     <= '0;
         state_q   <= ST_HOLD;
         hold_q    <= '0;
         stag_q    <= '0;
         idx_q     <= '0;
         out_q     <= '0;
         all_rel_q <= 1'b0;
         busy_q    <= 1'b1;
         count_q   <= '0;
      end else begin
         sync_q    <= sync_d;
         deb_q     <= deb_d;
         state_q   <= state_d;
         hold_q    <= hold_d;
         stag_q    <= stag_d;
         idx_q     <= idx_d;
         out_q     <= out_d;
         all_rel_q <= all_rel_d;
         busy_q    <= busy_d;
         count_q   <= count_d;
      end
   end

   assign reset_n_out  = out_q;
   assign all_released = all_rel_q;
   assign busy         = busy_q;
   assign reset_count  = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer with default parameters. A reference
// model tracks how many request-free edges have passed in the current reset
// episode and derives the released bit count arithmetically; outputs are
// compared against it every falling edge. Literal checks pin key timings.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reset_sequencer;

   localparam int unsigned NUM_OUT  = 2;
   localparam int unsigned SYNC     = 2;
   localparam int unsigned DEB      = 4;
   localparam int unsigned HOLD     = 8;
   localparam int unsigned STAGGER  = 4;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               hit_reset = 1'b0;
   logic               sw_reset = 1'b0;
   logic [NUM_OUT-1:0] reset_n_out;
   logic               all_released;
   logic               busy;
   logic [7:0]         reset_count;

   int checks = 0;
   int failures = 0;

   reset_sequencer #(
      .NUM_OUT(NUM_OUT), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAGGER), .CNT_W(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .hit_reset(hit_reset), .sw_reset(sw_reset),
      .reset_n_out(reset_n_out), .all_released(all_released), .busy(busy),
      .reset_count(reset_count)
   );

   always #5 clk = ~clk;

   // Reference model: m_t = request-free edges in this episode, m_hist = past
   // hit_reset samples (bit 0 most recent), m_rel = number of released bits.
   int unsigned m_t;
   int unsigned m_rel;
   int unsigned m_cnt;
   logic [31:0] m_hist;
   logic        m_req;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_t = 0; m_rel = 0; m_cnt = 0; m_hist = '0;
      end else begin
         // Request seen by the sequencer: DEB consecutive samples, SYNC edges old.
         m_req = (&m_hist[SYNC +: DEB]) | sw_reset;
         if (m_req && m_rel != 0 && m_cnt < 255) m_cnt = m_cnt + 1;
         if (m_req) m_t = 0;
         else if (m_t < 100000) m_t = m_t + 1;
         m_hist = {m_hist[30:0], hit_reset};
         if (m_t < HOLD) m_rel = 0;
         else begin
            m_rel = 1 + (m_t - HOLD) / STAGGER;
            if (m_rel > NUM_OUT) m_rel = NUM_OUT;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      chk("model_out", 32'(reset_n_out), (32'd1 << m_rel) - 32'd1);
      chk("model_all", 32'(all_released), 32'(m_rel == NUM_OUT));
      chk("model_busy", 32'(busy), 32'(m_rel != NUM_OUT));
      chk("model_cnt", 32'(reset_count), 32'(m_cnt));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic power_on_sequence(input string tag, input int exp_cnt);
      reset_n = 1'b0;
      tick(3);
      chk({tag, "_rst_out"}, 32'(reset_n_out), 32'd0);
      chk({tag, "_rst_busy"}, 32'(busy), 32'd1);
      reset_n = 1'b1;
      tick(7);
      chk({tag, "_e7_out"}, 32'(reset_n_out), 32'd0);
      tick(1);
      chk({tag, "_e8_out"}, 32'(reset_n_out), 32'd1);
      tick(3);
      chk({tag, "_e11_out"}, 32'(reset_n_out), 32'd1);
      chk({tag, "_e11_all"}, 32'(all_released), 32'd0);
      tick(1);
      chk({tag, "_e12_out"}, 32'(reset_n_out), 32'd3);
      chk({tag, "_e12_all"}, 32'(all_released), 32'd1);
      chk({tag, "_e12_busy"}, 32'(busy), 32'd0);
      chk({tag, "_cnt"}, 32'(reset_count), 32'(exp_cnt));
   endtask

   initial begin
      // Power-on timing.
      power_on_sequence("por", 0);
      tick(5);

      // Glitch rejection: 3-cycle pulse never debounces.
      hit_reset = 1'b1;
      tick(3);
      hit_reset = 1'b0;
      tick(12);
      chk("glitch_out", 32'(reset_n_out), 32'd3);
      chk("glitch_cnt", 32'(reset_count), 32'd0);

      // Button press held 20 cycles.
      hit_reset = 1'b1;
      tick(6);
      chk("btn_e6_out", 32'(reset_n_out), 32'd3);
      tick(1);
      chk("btn_e7_out", 32'(reset_n_out), 32'd0);
      chk("btn_e7_cnt", 32'(reset_count), 32'd1);
      tick(13);
      hit_reset = 1'b0;
      tick(10);
      chk("btn_e30_out", 32'(reset_n_out), 32'd0);
      tick(1);
      chk("btn_e31_out", 32'(reset_n_out), 32'd1);
      tick(3);
      chk("btn_e34_out", 32'(reset_n_out), 32'd1);
      tick(1);
      chk("btn_e35_out", 32'(reset_n_out), 32'd3);
      chk("btn_cnt", 32'(reset_count), 32'd1);
      tick(3);

      // sw_reset from RUN, then abort while partially released.
      sw_reset = 1'b1;
      tick(1);
      sw_reset = 1'b0;
      chk("sw_e1_out", 32'(reset_n_out), 32'd0);
      chk("sw_e1_cnt", 32'(reset_count), 32'd2);
      tick(8);
      chk("sw_e9_out", 32'(reset_n_out), 32'd1);
      sw_reset = 1'b1;
      tick(1);
      sw_reset = 1'b0;
      chk("abort_out", 32'(reset_n_out), 32'd0);
      chk("abort_cnt", 32'(reset_count), 32'd3);
      tick(7);
      chk("abort_e7_out", 32'(reset_n_out), 32'd0);
      tick(1);
      chk("abort_e8_out", 32'(reset_n_out), 32'd1);
      tick(4);
      chk("abort_e12_out", 32'(reset_n_out), 32'd3);
      tick(3);

      // sw_reset on the same edge req_lvl first asserts: counted once.
      hit_reset = 1'b1;
      tick(6);
      sw_reset = 1'b1;
      tick(1);
      sw_reset = 1'b0;
      hit_reset = 1'b0;
      chk("simul_out", 32'(reset_n_out), 32'd0);
      chk("simul_cnt", 32'(reset_count), 32'd4);
      tick(30);
      chk("simul_rel_out", 32'(reset_n_out), 32'd3);
      chk("simul_rel_cnt", 32'(reset_count), 32'd4);

      // Saturation: 300 accepted events, each aborting a partial release.
      for (int i = 0; i < 300; i++) begin
         sw_reset = 1'b1;
         tick(1);
         sw_reset = 1'b0;
         tick(8);
      end
      chk("sat_cnt", 32'(reset_count), 32'd255);
      chk("sat_out", 32'(reset_n_out), 32'd1);

      // Async reset mid-release: outputs drop without a clock edge.
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_out", 32'(reset_n_out), 32'd0);
      chk("async_cnt", 32'(reset_count), 32'd0);
      chk("async_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      power_on_sequence("rep", 0);
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
